// File: rtl/l2_burst_adaptor.sv
// l2_burst_adaptor: bridges whole-line L2 requests (s_line bits) to memory
// bursts of s_line/s_beat beats. Reads assemble beats into a line; writes
// serialise a latched line into beats. One resp_o pulse per line transfer.
// Optional build macro L2_ADAPTOR_PERF_EN adds read/write line counters and
// a stall-cycle counter.
module l2_burst_adaptor #(
  parameter int s_line   = 256,
  parameter int s_beat   = 64,
  parameter int s_offset = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [s_line-1:0] line_i,
  output logic [s_line-1:0] line_o,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [s_beat-1:0] burst_i,
  output logic [s_beat-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
`ifdef L2_ADAPTOR_PERF_EN
  ,
  output logic [31:0]       rd_lines_o,
  output logic [31:0]       wr_lines_o,
  output logic [31:0]       stall_cycles_o
`endif
);

  localparam int n_beats = s_line / s_beat;
  localparam int cnt_w   = $clog2(n_beats);
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(n_beats - 1);
  // Masking keeps every address bit in the datapath while forcing alignment.
  localparam logic [31:0] align_mask = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

  state_t             state_reg, state_next;
  logic [cnt_w-1:0]   cnt_reg, cnt_next, cnt_inc;
  logic [s_line-1:0]  buf_reg, buf_next;
  logic [s_line-1:0]  assembled;
  logic [s_beat-1:0]  buf_beats [n_beats];

  logic [s_line-1:0]  line_reg, line_next;
  logic [s_beat-1:0]  burst_reg, burst_next;
  logic [31:0]        addr_reg, addr_next;
  logic               read_reg, read_next;
  logic               write_reg, write_next;
  logic               resp_reg, resp_next;

  assign cnt_inc = cnt_reg + 1'b1;

  // Beat view of the shared line buffer, and the buffer with the incoming
  // read beat merged into the slot selected by the counter.
  generate
    for (genvar gi = 0; gi < n_beats; gi++) begin : g_beat
      assign buf_beats[gi] = buf_reg[gi*s_beat +: s_beat];
      assign assembled[gi*s_beat +: s_beat] =
        (cnt_reg == cnt_w'(gi)) ? burst_i : buf_reg[gi*s_beat +: s_beat];
    end
  endgenerate

  // State and registered outputs; reset returns everything to zero/IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      buf_reg   <= '0;
      line_reg  <= '0;
      burst_reg <= '0;
      addr_reg  <= '0;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      resp_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      buf_reg   <= buf_next;
      line_reg  <= line_next;
      burst_reg <= burst_next;
      addr_reg  <= addr_next;
      read_reg  <= read_next;
      write_reg <= write_next;
      resp_reg  <= resp_next;
    end
  end

  // Next-state and next-output logic; request strobes are recomputed each
  // cycle so they drop on the same edge that enters DONE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    buf_next   = buf_reg;
    line_next  = line_reg;
    burst_next = burst_reg;
    addr_next  = addr_reg;
    read_next  = 1'b0;
    write_next = 1'b0;
    resp_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        // Writeback is taken ahead of a fill when both are requested.
        if (write_i) begin
          state_next = WR_BURST;
          addr_next  = address_i & align_mask;
          buf_next   = line_i;
          burst_next = line_i[s_beat-1:0];
          cnt_next   = '0;
          write_next = 1'b1;
        end else if (read_i) begin
          state_next = RD_BURST;
          addr_next  = address_i & align_mask;
          cnt_next   = '0;
          read_next  = 1'b1;
        end
      end
      RD_BURST: begin
        read_next = 1'b1;
        if (resp_i) begin
          buf_next = assembled;
          cnt_next = cnt_inc;
          if (cnt_reg == last_beat) begin
            state_next = DONE;
            read_next  = 1'b0;
            resp_next  = 1'b1;
            line_next  = assembled;
          end
        end
      end
      WR_BURST: begin
        write_next = 1'b1;
        if (resp_i) begin
          cnt_next   = cnt_inc;
          burst_next = buf_beats[cnt_inc];
          if (cnt_reg == last_beat) begin
            state_next = DONE;
            write_next = 1'b0;
            resp_next  = 1'b1;
            burst_next = '0;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign line_o    = line_reg;
  assign burst_o   = burst_reg;
  assign address_o = addr_reg;
  assign read_o    = read_reg;
  assign write_o   = write_reg;
  assign resp_o    = resp_reg;

`ifdef L2_ADAPTOR_PERF_EN
  logic [31:0] rd_lines_reg, wr_lines_reg, stall_reg;

  // Completed-line and stalled-beat counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_lines_reg <= '0;
      wr_lines_reg <= '0;
      stall_reg    <= '0;
    end else begin
      if (state_reg == RD_BURST && state_next == DONE)
        rd_lines_reg <= rd_lines_reg + 32'd1;
      if (state_reg == WR_BURST && state_next == DONE)
        wr_lines_reg <= wr_lines_reg + 32'd1;
      if ((state_reg == RD_BURST || state_reg == WR_BURST) && !resp_i)
        stall_reg <= stall_reg + 32'd1;
    end
  end

  assign rd_lines_o     = rd_lines_reg;
  assign wr_lines_o     = wr_lines_reg;
  assign stall_cycles_o = stall_reg;
`endif

endmodule

// File: doc/l2_burst_adaptor.md
Name: l2_burst_adaptor

Overview:
Sits directly downstream of the L2 cache datapath, between it and physical memory. Converts whole-line requests from the L2 side (256-bit line, 32-bit address, read/write, single response) into 64-bit memory bursts of 4 beats. On a read it assembles the beats into one line. On a write it serialises the latched line into beats. It produces one response pulse per completed line transfer.

Parameters:
- s_line, 256, cacheline width in bits.
- s_beat, 64, memory beat width in bits; s_line/s_beat = beats per burst (4); beat counter width = $clog2(s_line/s_beat).
- s_offset, 5, address bits zeroed for line alignment.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- line_i  input  s_line  line to write back (from L2 cacheline_data_out)
- line_o  output  s_line  assembled read line (to L2 data_from_mem)
- address_i  input  32  line address from L2
- read_i  input  1  L2 line-read request, held until resp_o
- write_i  input  1  L2 line-write request, held until resp_o
- resp_o  output  1  one-cycle completion pulse
- burst_i  input  s_beat  read beat from memory
- burst_o  output  s_beat  write beat to memory
- address_o  output  32  burst address to memory, low s_offset bits zero
- read_o  output  1  memory read request
- write_o  output  1  memory write request
- resp_i  input  1  memory beat acknowledge, one beat per high cycle

Behaviour:
- All outputs are registered. Reset value of every output is 0, the beat counter is 0, and the state is IDLE.
- FSM states: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - Samples requests. If write_i is high, go to WR_BURST; write wins if read_i and write_i are both high (writeback precedes fill).
  - Else if read_i is high, go to RD_BURST.
  - On leaving IDLE: latch address_o = {address_i[31:s_offset], 0}; for a write, latch line_i into the shift buffer; clear the counter.
  - resp_i is ignored in IDLE.
- RD_BURST:
  - read_o = 1.
  - Each cycle resp_i = 1: beat k = counter is stored into line bits [64k+63:64k] (beat 0 is the least significant); counter increments.
  - Gaps (resp_i = 0) are allowed and hold state.
  - On the 4th beat, go to DONE and drop read_o on the next edge.
- WR_BURST:
  - write_o = 1 and burst_o = beat[counter] of the latched line.
  - Each resp_i = 1 advances the counter, and burst_o updates on the same edge.
  - On the 4th beat, go to DONE and drop write_o.
- DONE:
  - resp_o = 1 for exactly one cycle, then go to IDLE.
  - line_o holds the assembled line from DONE until the next read completes. Write transfers do not disturb line_o.
- Latency: request first seen high at cycle T → read_o/write_o high at T+1. With resp_i high at T+1..T+4, resp_o is high at T+5. Each resp_i gap cycle adds one cycle.
- Requester contract: read_i/write_i are held stable until resp_o and deasserted the cycle after it. The adaptor ignores changes to address_i, line_i, read_i and write_i outside IDLE.
- Counter wrap: the counter returns to 0 on entry to DONE. A resp_i in DONE is ignored; it is not counted toward a later burst.
- Reset mid-burst: next state is IDLE; read_o, write_o, resp_o, line_o and address_o all go to 0 on that edge; no resp_o is issued for the aborted transfer.

Optional Feature:
L2_ADAPTOR_PERF_EN
- When defined: adds outputs rd_lines_o [31:0], wr_lines_o [31:0] and stall_cycles_o [31:0].
  - rd_lines_o / wr_lines_o increment on each DONE entered from RD_BURST / WR_BURST.
  - stall_cycles_o increments on each RD_BURST/WR_BURST cycle with resp_i = 0.
  - All three reset to 0 on rst and wrap modulo 2^32.
- When undefined: these ports and registers do not exist, and the behaviour is otherwise identical.

Test Plan:
- Read, address_i = 0x0000_1234, burst_i = 0x11..11, 0x22..22, 0x33..33, 0x44..44 with resp_i at T+1..T+4 → address_o = 0x0000_1220, read_o at T+1..T+4, resp_o only at T+5, line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write, line_i = {0xDDDD.., 0xCCCC.., 0xBBBB.., 0xAAAA..}, resp_i with a 2-cycle gap after beat 1 → burst_o sequence AAAA, BBBB (held 3 cycles), CCCC, DDDD; resp_o at T+7; line_o unchanged from prior read.
- read_i = write_i = 1 in the same cycle → WR_BURST taken and write_o = 1, read_o stays 0 until the write's resp_o; a read then starts after read_i is re-presented in IDLE.
- rst asserted after 2 read beats → next cycle read_o = 0, line_o = 0, no resp_o; a fresh read completes normally with 4 new beats.
- Stray resp_i in IDLE and in DONE → no state change, counter unaffected, next burst still needs 4 beats.
- With L2_ADAPTOR_PERF_EN: 2 reads, 1 write, 3 gap cycles total → rd_lines_o = 2, wr_lines_o = 1, stall_cycles_o = 3; rst → all 0.
